div_iter: RTL and testbench

- Parametrised multi-cycle radix-2 restoring integer divider for the EX stage.
- Successor to the fixed 32-bit divider: adds WIDTH, working annul, a divide-by-zero flag, a busy indication and a defined zero-divisor result.
- EX drives operands and a start pulse, stalls the pipeline while busy_o is high, and takes {remainder, quotient} when ready_o pulses.

---
 rtl/div_iter.sv | 121 ++++++++++++
 tb/tb_div_iter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring integer divider (signed/unsigned) for the EX stage.
// Result, ready pulse and divide-by-zero flag are registered one edge after DONE.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_by_zero_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ZERO, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d, zf_q, zf_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d, dbz_q, dbz_d;

  logic               sign1, sign2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     trial, diff;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    zf_d     = zf_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    ready_d  = 1'b0;

    sign1 = signed_div_i & opdata1_i[WIDTH-1];
    sign2 = signed_div_i & opdata2_i[WIDTH-1];
    mag1  = sign1 ? -opdata1_i : opdata1_i;
    mag2  = sign2 ? -opdata2_i : opdata2_i;
    trial = {rem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, dvs_q};

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          dvs_d  = mag2;
          qneg_d = sign1 ^ sign2;
          rneg_d = sign1;
          cnt_d  = '0;
          // Zero divisor preloads the final {dividend, all-ones} so ZERO just waits an edge.
          zf_d   = (opdata2_i == '0);
          rem_d  = zf_d ? opdata1_i : '0;
          quo_d  = zf_d ? '1 : mag1;
          state_d = zf_d ? S_ZERO : S_BUSY;
        end
      end
      S_BUSY: begin
        if (annul_i) state_d = S_IDLE;
        else begin
          rem_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_DONE;
        end
      end
      S_ZERO: state_d = annul_i ? S_IDLE : S_DONE;
      S_DONE: begin
        state_d  = S_IDLE;
        ready_d  = 1'b1;
        dbz_d    = zf_q;
        result_d = zf_q ? {rem_q, quo_q}
                        : {(rneg_q ? -rem_q : rem_q), (qneg_q ? -quo_q : quo_q)};
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      zf_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      zf_q     <= zf_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      dbz_q    <= dbz_d;
    end
  end

  assign result_o      = result_q;
  assign ready_o       = ready_q;
  assign div_by_zero_o = dbz_q;
  assign busy_o        = (state_q == S_BUSY) || (state_q == S_ZERO);

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: 32-bit instance for the main cases, 8-bit instance for scaling.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sgn = 1'b0, start = 1'b0, annul = 1'b0;
  logic [31:0] op1 = '0, op2 = '0;
  logic [63:0] res;
  logic        ready, busy, dbz;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = 8'd100, b8 = 8'd7;
  logic [15:0] res8;
  logic        ready8, busy8, dbz8;

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          nchk = 0, nerr = 0;
  logic [63:0] prev_res = '0;

  div_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(sgn), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start), .annul_i(annul), .result_o(res), .ready_o(ready),
    .busy_o(busy), .div_by_zero_o(dbz)
  );

  div_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .signed_div_i(1'b0), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(start8), .annul_i(1'b0), .result_o(res8), .ready_o(ready8),
    .busy_o(busy8), .div_by_zero_o(dbz8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every ready pulse must match the oldest outstanding expectation, on time.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (sb.size() == 0) chk("spurious_ready", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", 64'(cyc), 64'(e.due));
        chk("result", res, e.res);
        chk("dbz", {63'd0, dbz}, {63'd0, e.dbz});
      end
    end
  end

  // poke: 1 = extra start pulses during BUSY and DONE, 2 = annul during DONE
  task automatic do_op(input bit sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] er, input bit ez, input int lat, input int poke);
    int bc, e0;
    @(negedge clk);
    sgn = sg; op1 = a; op2 = b; start = 1'b1;
    e0 = cyc + 1;
    sb.push_back('{er, ez, e0 + lat});
    @(negedge clk);
    start = 1'b0;
    chk("hold_prev_result", res, prev_res);
    bc = 0;
    for (int i = 0; i < lat + 10 && sb.size() != 0; i++) begin
      if (busy === 1'b1) bc++;
      if (poke == 1 && i == 3) start = 1'b1;
      else if (poke == 1 && cyc == e0 + lat - 1) start = 1'b1;
      else start = 1'b0;
      annul = (poke == 2 && cyc == e0 + lat - 1);
      @(negedge clk);
    end
    start = 1'b0; annul = 1'b0;
    chk("timeout", 64'(sb.size()), 64'd0);
    chk("busy_cycles", 64'(bc), 64'(lat - 1));
    @(negedge clk);
    chk("idle_after", {63'd0, busy}, 64'd0);
    prev_res = er;
  endtask

  initial begin
    int e0, n;
    repeat (2) @(negedge clk);
    chk("rst_result", res, 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_dbz", {63'd0, dbz}, 64'd0);
    rst = 1'b0;

    // start with annul in IDLE is ignored
    @(negedge clk); op1 = 32'd9; op2 = 32'd3; start = 1'b1; annul = 1'b1;
    @(negedge clk); start = 1'b0; annul = 1'b0;
    chk("start_annul_idle", {63'd0, busy}, 64'd0);

    do_op(0, 32'd100, 32'd7, {32'h2, 32'hE}, 0, 33, 0);
    do_op(1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 33, 0);
    do_op(1, 32'd7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 0, 33, 2);
    do_op(1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 0, 33, 0);
    do_op(0, 32'hFFFFFFF9, 32'd2, {32'h1, 32'h7FFFFFFC}, 0, 33, 1);
    do_op(0, 32'h12345678, 32'd0, {32'h12345678, 32'hFFFFFFFF}, 1, 2, 0);
    do_op(1, 32'h12345678, 32'd0, {32'h12345678, 32'hFFFFFFFF}, 1, 2, 1);
    do_op(1, 32'h80000005, 32'd0, {32'h80000005, 32'hFFFFFFFF}, 1, 2, 0);
    do_op(0, 32'd10, 32'd5, {32'h0, 32'h2}, 0, 33, 0);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom_range(1, 65535);
      do_op(0, a, b, {a % b, a / b}, 0, 33, 0);
    end

    // annul at iteration 10: no ready, result kept, then a clean restart
    @(negedge clk); sgn = 1'b0; op1 = 32'd20; op2 = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    annul = 1'b1;
    @(negedge clk); annul = 1'b0;
    chk("annul_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    chk("annul_result", res, prev_res);
    do_op(0, 32'd20, 32'd3, {32'h2, 32'h6}, 0, 33, 0);

    // reset at iteration 5 with a start poke during BUSY
    @(negedge clk); op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_result", res, 64'd0);
    chk("midrst_ready", {63'd0, ready}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_dbz", {63'd0, dbz}, 64'd0);
    prev_res = '0;
    repeat (40) @(negedge clk);
    chk("midrst_quiet", {63'd0, busy}, 64'd0);

    // 8-bit instance: 100/7
    @(negedge clk); start8 = 1'b1; e0 = cyc + 1;
    @(negedge clk); start8 = 1'b0;
    n = 0;
    while (ready8 !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
    end
    chk("w8_latency", 64'(cyc - e0), 64'd9);
    chk("w8_result", {48'd0, res8}, 64'h020E);
    chk("w8_dbz", {63'd0, dbz8}, 64'd0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
